// File: rtl/pulse_slot_arbiter.sv
// Purpose: round-robin arbiter that lends one fixed-length high pulse (y) to one of NREQ requesters at a time.
// Latency: req sampled at edge k gives y/grant high after edge k; y stays high PULSE_LEN cycles, then GAP low cycles plus one IDLE cycle.
// Backpressure: none; requests are level-sensitive and only sampled in IDLE, so a requester holds req until it sees grant.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   req        level request per requester
//   grant      one-hot grant, high for the whole pulse
//   active_id  binary index of the granted requester, 0 outside the pulse
//   y          shared pulse output
//   busy       high while pulsing or in the guard gap
//   done       one-cycle strobe on the first cycle after the last pulse cycle
module pulse_slot_arbiter #(
    parameter int NREQ      = 4,
    parameter int PULSE_LEN = 3,
    parameter int GAP       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  active_id,
    output logic                     y,
    output logic                     busy,
    output logic                     done
);

    localparam int IDW  = $clog2(NREQ);
    localparam int MAXC = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0]  PULSE_LAST = CW'(PULSE_LEN - 1);
    // With GAP==0 the GAP state is never entered, so its terminal value is irrelevant.
    localparam logic [CW-1:0]  GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IDW-1:0] LAST_RST   = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]  active_id_q, active_id_d;
    logic            y_q, y_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Round-robin pick: first set request scanning upward from the slot after the
    // previous winner, wrapping. i==NREQ revisits last_q itself, so a lone
    // requester that just won can win again.
    logic            win_vld;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  cand;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(last_q) + i) % NREQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        grant_d     = grant_q;
        active_id_d = active_id_q;
        y_d         = y_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d     = S_PULSE;
                    grant_d     = ONE_HOT0 << win_idx;
                    active_id_d = win_idx;
                    y_d         = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    last_d      = win_idx;
                end
            end

            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    y_d         = 1'b0;
                    grant_d     = '0;
                    active_id_d = '0;
                    done_d      = 1'b1;
                    cnt_d       = '0;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                grant_d     = '0;
                active_id_d = '0;
                y_d         = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= LAST_RST;
            grant_q     <= '0;
            active_id_q <= '0;
            y_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            active_id_q <= active_id_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign grant     = grant_q;
    assign active_id = active_id_q;
    assign y         = y_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pulse_slot_arbiter.sv
// Purpose: directed bench for pulse_slot_arbiter (default params plus a PULSE_LEN=1, GAP=0 instance).
// Latency: every check samples 1 time unit after a rising edge.
// Backpressure: not applicable; requests are driven as levels.
module tb_pulse_slot_arbiter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] active_id;
    logic       y, busy, done;

    // PULSE_LEN=1, GAP=0 instance
    logic       rst_s;
    logic [3:0] req_s;
    logic [3:0] grant_s;
    logic [1:0] active_id_s;
    logic       y_s, busy_s, done_s;

    int errors = 0;
    int checks = 0;

    pulse_slot_arbiter #(.NREQ(4), .PULSE_LEN(3), .GAP(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .active_id (active_id),
        .y         (y),
        .busy      (busy),
        .done      (done)
    );

    pulse_slot_arbiter #(.NREQ(4), .PULSE_LEN(1), .GAP(0)) u_short (
        .clk       (clk),
        .rst       (rst_s),
        .req       (req_s),
        .grant     (grant_s),
        .active_id (active_id_s),
        .y         (y_s),
        .busy      (busy_s),
        .done      (done_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held with all requests set: everything stays low; first grant goes to index 0.
    task automatic test_reset();
        rst = 1'b0;
        req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({y, grant, busy, done} !== 7'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: got y/grant/busy/done=%b expected 0000000", c, {y, grant, busy, done});
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({y, grant, active_id} !== {1'b1, 4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL reset_first_grant: got y/grant/id=%b expected 1000100", {y, grant, active_id});
        end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    // One-edge request from index 2: 3 pulse cycles, done, then idle.
    task automatic test_single();
        logic [8:0] exp_v [6];
        // {y, grant, active_id, busy, done}
        exp_v = '{9'b1_0100_10_1_0, 9'b1_0100_10_1_0, 9'b1_0100_10_1_0,
                  9'b0_0000_00_1_1, 9'b0_0000_00_0_0, 9'b0_0000_00_0_0};
        req = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) req = 4'b0000;
            checks++;
            if ({y, grant, active_id, busy, done} !== exp_v[c]) begin
                errors++;
                $display("FAIL single cycle %0d: got %b expected %b", c + 1, {y, grant, active_id, busy, done}, exp_v[c]);
            end
        end
    endtask

    // All requesters held from reset release: 0,1,2,3,0 each for 3 cycles, 2 low cycles between.
    task automatic test_round_robin();
        logic [8:0] e;
        int k, p;
        rst = 1'b0;
        req = 4'b1111;
        tick();
        rst = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            k = (c - 1) / 5;
            p = (c - 1) % 5;
            if (p < 3)       e = {1'b1, 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0};
            else if (p == 3) e = 9'b0_0000_00_1_1;
            else             e = 9'b0_0000_00_0_0;
            checks++;
            if ({y, grant, active_id, busy, done} !== e) begin
                errors++;
                $display("FAIL round_robin cycle %0d: got %b expected %b", c, {y, grant, active_id, busy, done}, e);
            end
        end
        req = 4'b0000;
    endtask

    // Previous winner index 2, requests {0,1}: scan wraps past 3 to 0, then 1.
    task automatic test_skip_wrap();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL skip_wrap_setup: got grant=%b expected 0100", grant);
        end
        repeat (4) tick();
        req = 4'b0011;
        tick();
        checks++;
        if ({grant, active_id} !== {4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL skip_wrap_first: got grant/id=%b expected 000100", {grant, active_id});
        end
        repeat (4) tick();
        tick();
        checks++;
        if ({grant, active_id} !== {4'b0010, 2'd1}) begin
            errors++;
            $display("FAIL skip_wrap_second: got grant/id=%b expected 001001", {grant, active_id});
        end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    // Request dropped during the pulse: pulse still runs its full length.
    task automatic test_req_drop();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            checks++;
            if ({y, grant, active_id} !== {1'b1, 4'b1000, 2'd3}) begin
                errors++;
                $display("FAIL req_drop cycle %0d: got y/grant/id=%b expected 1100011", c, {y, grant, active_id});
            end
        end
        tick();
        checks++;
        if ({y, grant, busy, done} !== 7'b0_0000_1_1) begin
            errors++;
            $display("FAIL req_drop_done: got y/grant/busy/done=%b expected 0000011", {y, grant, busy, done});
        end
        tick();
    endtask

    // Reset on the 2nd pulse cycle kills the pulse; pointer restarts at index 0.
    task automatic test_mid_reset();
        req = 4'b0100;
        tick();
        tick();
        checks++;
        if ({y, grant} !== 5'b1_0100) begin
            errors++;
            $display("FAIL mid_reset_pulse: got y/grant=%b expected 10100", {y, grant});
        end
        rst = 1'b0;
        req = 4'b1111;
        tick();
        checks++;
        if ({y, grant, active_id, busy, done} !== 9'b0) begin
            errors++;
            $display("FAIL mid_reset_cleared: got %b expected 000000000", {y, grant, active_id, busy, done});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({y, grant, active_id} !== {1'b1, 4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset_regrant: got y/grant/id=%b expected 1000100", {y, grant, active_id});
        end
        req = 4'b0000;
        repeat (4) tick();
    endtask

    // PULSE_LEN=1, GAP=0 with requests {0,1}: y 1,0,1,0..., done on every low cycle.
    task automatic test_short_params();
        logic [8:0] e;
        int k;
        req_s = 4'b0011;
        rst_s = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            k = (c - 1) / 2;
            if ((c % 2) == 1) e = {1'b1, ((k % 2) == 0) ? 4'b0001 : 4'b0010, 2'(k % 2), 1'b1, 1'b0};
            else              e = 9'b0_0000_00_0_1;
            checks++;
            if ({y_s, grant_s, active_id_s, busy_s, done_s} !== e) begin
                errors++;
                $display("FAIL short_params cycle %0d: got %b expected %b", c, {y_s, grant_s, active_id_s, busy_s, done_s}, e);
            end
        end
        req_s = 4'b0000;
        tick();
    endtask

    initial begin
        rst   = 1'b0;
        req   = 4'b0000;
        rst_s = 1'b0;
        req_s = 4'b0000;

        test_reset();
        test_single();
        test_round_robin();
        test_skip_wrap();
        test_req_drop();
        test_mid_reset();
        test_short_params();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_slot_arbiter.md
Name: pulse_slot_arbiter

Overview:
- Round-robin scheduler that shares one fixed-length high-pulse output (`y`) among NREQ requesters.
- Grants one requester at a time and drives `y` high for exactly PULSE_LEN cycles, then enforces a guard gap before the next grant.
- Sequences the 3-cycle-high pulse resource when several agents contend for it.

Parameters:
- NREQ, 4, number of requesters (>= 2).
- PULSE_LEN, 3, cycles `y` is high per grant (>= 1).
- GAP, 1, extra forced-low cycles after each pulse (>= 0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clk).
- req  input  NREQ  level request per requester.
- grant  output  NREQ  one-hot grant, high for the whole pulse.
- active_id  output  $clog2(NREQ)  binary index of granted requester; 0 when not in PULSE.
- y  output  1  shared pulse output.
- busy  output  1  high in PULSE or GAP.
- done  output  1  one-cycle strobe on the first cycle after the last pulse cycle.

Behaviour:
- All outputs are registered. Reset (rst==0 at edge) forces:
  - state=IDLE, y=0, grant=0, active_id=0, busy=0, done=0;
  - counter=0, RR pointer last=NREQ-1, so index 0 has first priority.
- Reset overrides everything, including mid-pulse: outputs are 0 after that edge and the pulse is not resumed.
- States: IDLE, PULSE, GAP.
- IDLE:
  - Outputs low (done may be high, see below).
  - If |req at an edge: winner = first set bit scanning (last+1) mod NREQ upward with wrap. At that same edge: state becomes PULSE, grant=onehot(winner), active_id=winner, y=1, busy=1, cnt=0, last=winner.
  - Latency: req sampled high at edge k -> y high after edge k.
- PULSE:
  - y, grant and active_id are held constant; cnt increments each edge.
  - When cnt==PULSE_LEN-1 at an edge:
    - y=0, grant=0, active_id=0, done=1;
    - go to GAP with cnt=0 if GAP>0, else go to IDLE.
  - Total y-high cycles is exactly PULSE_LEN.
  - req changes during PULSE are ignored: no abort, no preemption, winner unchanged.
- GAP:
  - y=0, busy=1; done is high only on its first cycle.
  - After GAP cycles, go to IDLE with busy=0.
  - Requests are not sampled in GAP.
- done is a single cycle in every case, including GAP=0 (then it is high during the IDLE cycle).
- Minimum y-low spacing between consecutive pulses is GAP+1 cycles, since IDLE always spends one cycle arbitrating.
- Pointer wrap: after grant to NREQ-1, the scan starts at 0.
- A requester that holds req continuously is served once per round; no requester is starved.
- cnt width is $clog2(max(PULSE_LEN,GAP)+1). Counters never exceed their terminal values.
- Invariants: grant is always zero or one-hot; grant!=0 iff y==1.

Test Plan:
- Reset: rst=0 for 3 cycles with req=4'b1111 -> y=0, grant=0, busy=0, done=0 throughout; the first grant after release is 4'b0001.
- Single request: req=4'b0100 for one edge in IDLE -> next cycle y=1, grant=4'b0100, active_id=2 for exactly 3 cycles; then done=1 for 1 cycle; y low >= 2 cycles; busy high for 4 cycles.
- Round robin: req=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001 in order, each 3 cycles of y, with exactly 2 low cycles between pulses.
- Skip and wrap: last grant=4'b0100, req=4'b0011 -> next grant 4'b0001, then 4'b0010.
- Request drop / mid-pulse reset:
  - req deasserted on the 2nd pulse cycle -> pulse still completes 3 cycles.
  - rst=0 on the 2nd pulse cycle -> y=0, grant=0 after that edge; after release with req=4'b1111, the grant is 4'b0001.
- Params PULSE_LEN=1, GAP=0, req=4'b0011 held -> y pattern 1,0,1,0; grants alternate 0001/0010; done high on each 0 cycle.
